// File: rtl/ds_bitstream_tx.sv
// First-order delta-sigma transmitter: signed 8-bit samples in, 1-bit stream out.
// One output bit per SAMPLE_RATE_DIV clocks; each sample is held for an OSR-bit frame.
module ds_bitstream_tx #(
  parameter int unsigned SAMPLE_RATE_DIV = 64,
  parameter int unsigned OSR             = 8,
  parameter int unsigned UNDERRUN_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [7:0]            sample_in,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  input  logic                  clr_underrun,
  output logic                  bit_out,
  output logic                  bit_strobe,
  output logic                  frame_start,
  output logic [UNDERRUN_W-1:0] underrun_count
);

  localparam int unsigned DIV_W  = (SAMPLE_RATE_DIV > 1) ? $clog2(SAMPLE_RATE_DIV) : 1;
  localparam int unsigned SLOT_W = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [DIV_W-1:0]      DIV_LAST  = DIV_W'(SAMPLE_RATE_DIV - 1);
  localparam logic [SLOT_W-1:0]     SLOT_LAST = SLOT_W'(OSR - 1);
  localparam logic [UNDERRUN_W-1:0] UC_MAX    = '1;

  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic [8:0]            acc_q, acc_d;
  logic [7:0]            cur_q, cur_d;
  logic [7:0]            pend_q, pend_d;
  logic                  pend_full_q, pend_full_d;
  logic                  bit_q, bit_d;
  logic                  strobe_q, strobe_d;
  logic                  fs_q, fs_d;
  logic [UNDERRUN_W-1:0] uc_q, uc_d;

  logic       tick;
  logic       boundary;
  logic       accept;
  logic [7:0] u;
  logic [8:0] sum;

  assign tick     = enable && (div_cnt_q == DIV_LAST);
  assign boundary = tick && (slot_q == SLOT_LAST);
  assign accept   = sample_valid && !pend_full_q;
  // Flipping the sign bit maps signed -128..127 onto unsigned 0..255 (i.e. +128).
  assign u        = cur_q ^ 8'h80;
  // acc_q[8] is always 0, so this equals {1'b0, acc[7:0]} + u.
  assign sum      = acc_q + {1'b0, u};

  always_comb begin
    div_cnt_d   = div_cnt_q;
    slot_d      = slot_q;
    acc_d       = acc_q;
    cur_d       = cur_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    bit_d       = bit_q;
    strobe_d    = 1'b0;
    fs_d        = 1'b0;
    uc_d        = uc_q;

    if (enable) begin
      div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
    end

    if (tick) begin
      bit_d    = sum[8];
      acc_d    = {1'b0, sum[7:0]};
      strobe_d = 1'b1;
      fs_d     = (slot_q == '0);
      slot_d   = (slot_q == SLOT_LAST) ? '0 : slot_q + SLOT_W'(1);
    end

    if (accept) begin
      pend_d      = sample_in;
      pend_full_d = 1'b1;
    end

    // Frame boundary: promote the pending sample, or fall back to midscale.
    if (boundary) begin
      if (pend_full_q) begin
        cur_d       = pend_q;
        pend_full_d = 1'b0;
      end else begin
        cur_d = '0;
        if (uc_q != UC_MAX) begin
          uc_d = uc_q + UNDERRUN_W'(1);
        end
      end
    end

    if (clr_underrun) begin
      uc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q   <= '0;
      slot_q      <= '0;
      acc_q       <= '0;
      cur_q       <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      bit_q       <= 1'b0;
      strobe_q    <= 1'b0;
      fs_q        <= 1'b0;
      uc_q        <= '0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      slot_q      <= slot_d;
      acc_q       <= acc_d;
      cur_q       <= cur_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      bit_q       <= bit_d;
      strobe_q    <= strobe_d;
      fs_q        <= fs_d;
      uc_q        <= uc_d;
    end
  end

  assign sample_ready   = !pend_full_q;
  assign bit_out        = bit_q;
  assign bit_strobe     = strobe_q;
  assign frame_start    = fs_q;
  assign underrun_count = uc_q;

endmodule

// File: tb/tb_ds_bitstream_tx.sv
// Bench for ds_bitstream_tx: reference model feeds a scoreboard of expected bits,
// plus directed checks of latency, backpressure, freeze, clear, reset and saturation.
module tb_ds_bitstream_tx;

  localparam int DIV = 64;
  localparam int OSR = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [7:0] sample_in;
  logic       sample_valid;
  logic       sample_ready;
  logic       clr_underrun;
  logic       bit_out;
  logic       bit_strobe;
  logic       frame_start;
  logic [7:0] underrun_count;

  logic       sat_ready, sat_bit, sat_strobe, sat_fs;
  logic [7:0] sat_uc;

  always #5 clk = ~clk;

  ds_bitstream_tx #(.SAMPLE_RATE_DIV(DIV), .OSR(OSR), .UNDERRUN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sample_in(sample_in),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .clr_underrun(clr_underrun),
    .bit_out(bit_out), .bit_strobe(bit_strobe), .frame_start(frame_start),
    .underrun_count(underrun_count)
  );

  // Fast instance that reaches underrun saturation in about a thousand cycles.
  ds_bitstream_tx #(.SAMPLE_RATE_DIV(2), .OSR(2), .UNDERRUN_W(8)) u_sat (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sample_in(8'd0),
    .sample_valid(1'b0), .sample_ready(sat_ready), .clr_underrun(1'b0),
    .bit_out(sat_bit), .bit_strobe(sat_strobe), .frame_start(sat_fs),
    .underrun_count(sat_uc)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model, updated on each clock edge from its own state.
  int         m_div, m_slot, m_acc, m_uc, m_sum;
  logic [7:0] m_cur, m_pend;
  logic       m_full, m_strobe, m_tick, m_take;
  logic       exp_b[$];
  logic       exp_fs[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_div = 0; m_slot = 0; m_acc = 0; m_uc = 0;
      m_cur = 8'd0; m_pend = 8'd0; m_full = 1'b0; m_strobe = 1'b0;
      exp_b.delete(); exp_fs.delete();
    end else begin
      m_tick   = enable && (m_div == DIV - 1);
      m_take   = sample_valid && !m_full;
      m_strobe = m_tick;
      if (enable) m_div = (m_div + 1) % DIV;
      if (m_tick) begin
        m_sum = m_acc + (int'($signed(m_cur)) + 128);
        exp_b.push_back(m_sum >= 256);
        exp_fs.push_back(m_slot == 0);
        m_acc = m_sum % 256;
        if (m_slot == OSR - 1) begin
          if (m_full) begin
            m_cur  = m_pend;
            m_full = 1'b0;
          end else begin
            m_cur = 8'd0;
            if (m_uc < 255) m_uc++;
          end
        end
        m_slot = (m_slot + 1) % OSR;
      end
      if (m_take) begin
        m_pend = sample_in;
        m_full = 1'b1;
      end
      if (clr_underrun) m_uc = 0;
    end
  end

  // Monitor: compares against the scoreboard and records emitted bits.
  logic cap_q[$];
  logic cap_fs[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (bit_strobe || m_strobe) chk_eq("strobe", bit_strobe, m_strobe);
      if (bit_strobe) begin
        cap_q.push_back(bit_out);
        cap_fs.push_back(frame_start);
        chk_eq("sb_nonempty", exp_b.size() > 0, 1);
        if (exp_b.size() > 0) begin
          chk_eq("sb_bit", bit_out, exp_b.pop_front());
          chk_eq("sb_frame_start", frame_start, exp_fs.pop_front());
        end
        chk_eq("underrun_count", underrun_count, m_uc);
      end
      if (frame_start) chk_eq("fs_with_strobe", bit_strobe, 1);
      if (sample_valid) chk_eq("ready", sample_ready, !m_full);
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_cap(input int n);
    for (int i = 0; i < 20000 && cap_q.size() < n; i++) step();
    chk_eq("wait_cap", cap_q.size(), n);
  endtask

  task automatic count_to_strobe(output int lat);
    lat = 0;
    for (int i = 1; i <= 4 * DIV; i++) begin
      step();
      if (bit_strobe) begin
        lat = i;
        break;
      end
    end
  endtask

  // Holds valid until the sample is taken; reports the moment ready was seen.
  task automatic send(input logic [7:0] s, input string tag, output int at_cap,
                      output logic at_strobe);
    sample_valid = 1'b1;
    sample_in    = s;
    for (int i = 0; i < 2000 && !sample_ready; i++) step();
    chk_eq({tag, "_accept"}, sample_ready, 1);
    at_cap    = cap_q.size();
    at_strobe = bit_strobe;
    step();
    sample_valid = 1'b0;
  endtask

  task automatic chk_frame(input string tag, input int base, input logic [7:0] pat);
    for (int i = 0; i < 8; i++) chk_eq(tag, cap_q[base + i], pat[7 - i]);
    chk_eq({tag, "_fs"}, cap_fs[base], 1);
  endtask

  int   lat, at_cap, ones;
  logic at_strobe, frozen_bit;

  initial begin
    rst_n = 1'b0; enable = 1'b0; sample_valid = 1'b0; sample_in = 8'd0; clr_underrun = 1'b0;
    repeat (3) step();
    chk_eq("rst_ready", sample_ready, 1);
    chk_eq("rst_bit_out", bit_out, 0);
    chk_eq("rst_bit_strobe", bit_strobe, 0);
    chk_eq("rst_frame_start", frame_start, 0);
    chk_eq("rst_underrun", underrun_count, 0);

    rst_n = 1'b1; enable = 1'b1;
    count_to_strobe(lat);
    chk_eq("first_strobe_latency", lat, DIV);
    chk_eq("first_frame_start", frame_start, 1);

    send(8'd64, "s64", at_cap, at_strobe);
    wait_cap(24);
    chk_frame("f1_midscale", 0, 8'b0101_0101);
    chk_frame("f2_s64", 8, 8'b0111_0111);
    ones = 0;
    for (int i = 8; i < 16; i++) ones += int'(cap_q[i]);
    chk_eq("f2_ones", ones, 6);
    chk_frame("f3_midscale", 16, 8'b0101_0101);
    chk_eq("uc_after_f3", underrun_count, 2);

    send(8'h80, "s_neg128", at_cap, at_strobe);
    send(8'h7f, "s_127", at_cap, at_strobe);
    chk_eq("bp_ready_cap", at_cap, 32);
    chk_eq("bp_ready_strobe", at_strobe, 1);
    wait_cap(48);
    chk_frame("f4_midscale", 24, 8'b0101_0101);
    chk_frame("f5_neg128", 32, 8'b0000_0000);
    chk_frame("f6_127", 40, 8'b0111_1111);
    chk_eq("uc_after_f6", underrun_count, 3);

    wait_cap(51);
    enable     = 1'b0;
    frozen_bit = bit_out;
    repeat (100) step();
    chk_eq("freeze_no_strobes", cap_q.size(), 51);
    chk_eq("freeze_bit_out", bit_out, frozen_bit);
    enable = 1'b1;
    count_to_strobe(lat);
    chk_eq("resume_latency", lat, DIV);
    chk_eq("resume_slot_fs", frame_start, 0);
    wait_cap(57);
    chk_eq("resume_next_frame_start", cap_fs[56], 1);

    wait_cap(63);
    chk_eq("uc_before_clear", underrun_count, 4);
    repeat (DIV - 1) step();
    clr_underrun = 1'b1;
    step();
    clr_underrun = 1'b0;
    chk_eq("clear_cap", cap_q.size(), 64);
    chk_eq("clear_wins", underrun_count, 0);

    send(8'd100, "s100", at_cap, at_strobe);
    chk_eq("pending_full", sample_ready, 0);
    for (int i = 0; i < 4 * DIV && !(bit_strobe && bit_out); i++) step();
    chk_eq("pre_reset_bit", bit_out, 1);
    #1 rst_n = 1'b0;
    #1;
    chk_eq("async_rst_ready", sample_ready, 1);
    chk_eq("async_rst_bit_out", bit_out, 0);
    chk_eq("async_rst_strobe", bit_strobe, 0);
    cap_q.delete();
    cap_fs.delete();
    repeat (2) step();
    rst_n = 1'b1;
    wait_cap(16);
    chk_frame("post_rst_f1", 0, 8'b0101_0101);
    chk_frame("post_rst_f2", 8, 8'b0101_0101);
    chk_eq("post_rst_uc", underrun_count, 2);
    chk_eq("sat_uc", sat_uc, 255);
    repeat (40) step();
    chk_eq("sat_uc_hold", sat_uc, 255);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not complete, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
